// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO stimulus blocks.
package nco_pkg;
  localparam int NCO_WIDTH = 32;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_REPEAT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep sequencer feeding an NCO tuning word.
// All outputs registered; abort beats start, config latched only on start.
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int WIDTH   = NCO_WIDTH,
  parameter int STEP_W  = 12,
  parameter int DWELL_W = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_mode,
  input  logic [WIDTH-1:0]   i_f_start,
  input  logic [WIDTH-1:0]   i_f_step,
  input  logic [STEP_W-1:0]  i_n_steps,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic [WIDTH-1:0]   o_phase,
  output logic               o_step_strobe,
  output logic [STEP_W-1:0]  o_step_idx,
  output logic               o_busy,
  output logic               o_done
);

  state_t               r_state,     w_state_nxt;
  logic [WIDTH-1:0]     r_phase,     w_phase_nxt;
  logic [WIDTH-1:0]     r_f_start,   w_f_start_nxt;
  logic [WIDTH-1:0]     r_f_step,    w_f_step_nxt;
  logic [STEP_W-1:0]    r_n_eff,     w_n_eff_nxt;
  logic [STEP_W-1:0]    r_step_idx,  w_step_idx_nxt;
  logic [DWELL_W-1:0]   r_dwell_eff, w_dwell_eff_nxt;
  logic [DWELL_W-1:0]   r_dwell_cnt, w_dwell_cnt_nxt;
  logic                 r_mode,      w_mode_nxt;
  logic                 r_strobe,    w_strobe_nxt;
  logic                 r_done,      w_done_nxt;
  logic                 r_busy,      w_busy_nxt;

  // Zero step count / dwell behave as one so every sweep has at least one cycle.
  logic [STEP_W-1:0]  w_n_clamp;
  logic [DWELL_W-1:0] w_dwell_clamp;
  assign w_n_clamp     = (i_n_steps == '0) ? STEP_W'(1)  : i_n_steps;
  assign w_dwell_clamp = (i_dwell   == '0) ? DWELL_W'(1) : i_dwell;

  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_f_start_nxt   = r_f_start;
    w_f_step_nxt    = r_f_step;
    w_n_eff_nxt     = r_n_eff;
    w_step_idx_nxt  = r_step_idx;
    w_dwell_eff_nxt = r_dwell_eff;
    w_dwell_cnt_nxt = r_dwell_cnt;
    w_mode_nxt      = r_mode;
    w_strobe_nxt    = 1'b0;
    w_done_nxt      = 1'b0;

    case (r_state)
      IDLE: begin
        w_phase_nxt     = '0;
        w_step_idx_nxt  = '0;
        w_dwell_cnt_nxt = '0;
        if (i_start) begin
          w_f_start_nxt   = i_f_start;
          w_f_step_nxt    = i_f_step;
          w_n_eff_nxt     = w_n_clamp;
          w_dwell_eff_nxt = w_dwell_clamp;
          w_mode_nxt      = i_mode;
          w_phase_nxt     = i_f_start;
          w_strobe_nxt    = 1'b1;
          w_state_nxt     = RUN;
        end
      end
      RUN: begin
        if (r_dwell_cnt == r_dwell_eff - DWELL_W'(1)) begin
          w_dwell_cnt_nxt = '0;
          if (r_step_idx < r_n_eff - STEP_W'(1)) begin
            w_phase_nxt    = r_phase + r_f_step;
            w_step_idx_nxt = r_step_idx + STEP_W'(1);
            w_strobe_nxt   = 1'b1;
          end else if (r_mode == MODE_REPEAT) begin
            w_phase_nxt    = r_f_start;
            w_step_idx_nxt = '0;
            w_strobe_nxt   = 1'b1;
          end else begin
            w_phase_nxt    = '0;
            w_step_idx_nxt = '0;
            w_done_nxt     = 1'b1;
            w_state_nxt    = DONE;
          end
        end else begin
          w_dwell_cnt_nxt = r_dwell_cnt + DWELL_W'(1);
        end
      end
      DONE: begin
        w_phase_nxt     = '0;
        w_step_idx_nxt  = '0;
        w_dwell_cnt_nxt = '0;
        w_state_nxt     = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Abort overrides everything above, including a same-cycle start.
    if (i_abort) begin
      w_state_nxt     = IDLE;
      w_phase_nxt     = '0;
      w_step_idx_nxt  = '0;
      w_dwell_cnt_nxt = '0;
      w_strobe_nxt    = 1'b0;
      w_done_nxt      = 1'b0;
    end

    w_busy_nxt = (w_state_nxt == RUN);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_f_start   <= '0;
      r_f_step    <= '0;
      r_n_eff     <= '0;
      r_step_idx  <= '0;
      r_dwell_eff <= '0;
      r_dwell_cnt <= '0;
      r_mode      <= MODE_SINGLE;
      r_strobe    <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_f_start   <= w_f_start_nxt;
      r_f_step    <= w_f_step_nxt;
      r_n_eff     <= w_n_eff_nxt;
      r_step_idx  <= w_step_idx_nxt;
      r_dwell_eff <= w_dwell_eff_nxt;
      r_dwell_cnt <= w_dwell_cnt_nxt;
      r_mode      <= w_mode_nxt;
      r_strobe    <= w_strobe_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign o_phase       = r_phase;
  assign o_step_strobe = r_strobe;
  assign o_step_idx    = r_step_idx;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: vector table, directed corner sequences, and
// randomized traffic checked every cycle against a cycle-count reference model.
module tb_nco_sweep_ctrl;
  localparam int W  = 32;
  localparam int SW = 12;
  localparam int DW = 16;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic          i_mode = 1'b0;
  logic [W-1:0]  i_f_start = '0;
  logic [W-1:0]  i_f_step = '0;
  logic [SW-1:0] i_n_steps = '0;
  logic [DW-1:0] i_dwell = '0;
  logic [W-1:0]  o_phase;
  logic          o_step_strobe;
  logic [SW-1:0] o_step_idx;
  logic          o_busy;
  logic          o_done;

  nco_sweep_ctrl #(.WIDTH(W), .STEP_W(SW), .DWELL_W(DW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
    .i_mode(i_mode), .i_f_start(i_f_start), .i_f_step(i_f_step),
    .i_n_steps(i_n_steps), .i_dwell(i_dwell), .o_phase(o_phase),
    .o_step_strobe(o_step_strobe), .o_step_idx(o_step_idx), .o_busy(o_busy),
    .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a sweep is "cycle k since start"; outputs follow by arithmetic.
  bit          m_run = 1'b0;
  bit          m_done = 1'b0;
  int          m_k = 0;
  int          m_n = 1;
  int          m_d = 1;
  bit          m_mode = 1'b0;
  logic [W-1:0] m_fs = '0;
  logic [W-1:0] m_fst = '0;

  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      m_run = 1'b0; m_done = 1'b0; m_k = 0;
    end else if (i_abort) begin
      m_run = 1'b0; m_done = 1'b0;
    end else if (m_run) begin
      m_k++;
      if (!m_mode && m_k == m_n * m_d) begin
        m_run = 1'b0; m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (i_start) begin
      m_run = 1'b1; m_k = 0; m_mode = i_mode;
      m_fs = i_f_start; m_fst = i_f_step;
      m_n = (i_n_steps == 0) ? 1 : int'(i_n_steps);
      m_d = (i_dwell == 0) ? 1 : int'(i_dwell);
    end
  end

  always @(negedge i_clk) begin : model_chk
    logic [W-1:0] ep;
    int pos;
    int stp;
    if (chk_en) begin
      if (m_run) begin
        pos = m_mode ? (m_k % (m_n * m_d)) : m_k;
        stp = pos / m_d;
        ep  = m_fs + m_fst * W'(stp);
        chk("mdl_phase",  o_phase, ep);
        chk("mdl_idx",    o_step_idx, SW'(stp));
        chk("mdl_strobe", o_step_strobe, (pos % m_d) == 0);
        chk("mdl_busy",   o_busy, 1'b1);
        chk("mdl_done",   o_done, 1'b0);
      end else begin
        chk("mdl_phase",  o_phase, '0);
        chk("mdl_idx",    o_step_idx, '0);
        chk("mdl_strobe", o_step_strobe, 1'b0);
        chk("mdl_busy",   o_busy, 1'b0);
        chk("mdl_done",   o_done, m_done);
      end
    end
  end

  typedef struct {
    logic [W-1:0]  fs;
    logic [W-1:0]  fst;
    logic [SW-1:0] n;
    logic [DW-1:0] d;
    int            exp_busy;
    logic [W-1:0]  exp_last;
  } vec_t;

  vec_t vecs[5];

  task automatic launch(input logic [W-1:0] fs, input logic [W-1:0] fst,
                        input logic [SW-1:0] n, input logic [DW-1:0] d, input logic md);
    @(negedge i_clk);
    i_f_start = fs; i_f_step = fst; i_n_steps = n; i_dwell = d; i_mode = md;
    i_start = 1'b1;
  endtask

  // Basic 4x3 sweep; optionally pokes start with new config mid-sweep.
  task automatic run_basic(input bit poke);
    logic [W-1:0] ph [4];
    ph[0] = 32'h0100_0000; ph[1] = 32'h0180_0000;
    ph[2] = 32'h0200_0000; ph[3] = 32'h0280_0000;
    launch(32'h0100_0000, 32'h0080_0000, 12'd4, 16'd3, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      chk("basic_phase",  o_phase, ph[(c - 1) / 3]);
      chk("basic_strobe", o_step_strobe, ((c - 1) % 3) == 0);
      chk("basic_busy",   o_busy, 1'b1);
      if (poke && c == 5) begin
        i_start = 1'b1; i_f_start = 32'hDEAD_BEEF; i_f_step = 32'h1;
        i_n_steps = 12'd9; i_dwell = 16'd1; i_mode = 1'b1;
      end
    end
    @(negedge i_clk);
    chk("basic_done",   o_done, 1'b1);
    chk("basic_dbusy",  o_busy, 1'b0);
    chk("basic_dphase", o_phase, '0);
    @(negedge i_clk);
    chk("basic_after_done", o_done, 1'b0);
  endtask

  initial begin
    int busy_n;
    int cyc;
    logic [W-1:0] last;

    vecs[0] = '{32'h0100_0000, 32'h0080_0000, 12'd4, 16'd3, 12, 32'h0280_0000};
    vecs[1] = '{32'hFFFF_FFF0, 32'h0000_0020, 12'd2, 16'd1, 2,  32'h0000_0010};
    vecs[2] = '{32'h0000_1234, 32'h0000_0005, 12'd0, 16'd0, 1,  32'h0000_1234};
    vecs[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 12'd3, 16'd2, 6,  32'hFFFF_FFFE};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 12'd1, 16'd5, 5,  32'h8000_0000};

    repeat (3) @(negedge i_clk);
    chk("rst_phase", o_phase, '0);
    chk("rst_busy",  o_busy, 1'b0);
    chk("rst_done",  o_done, 1'b0);
    chk("rst_strb",  o_step_strobe, 1'b0);
    chk("rst_idx",   o_step_idx, '0);
    i_reset = 1'b1;
    chk_en = 1'b1;

    for (int v = 0; v < 5; v++) begin
      launch(vecs[v].fs, vecs[v].fst, vecs[v].n, vecs[v].d, 1'b0);
      busy_n = 0; cyc = 0; last = '0;
      @(negedge i_clk);
      i_start = 1'b0;
      while (o_busy && cyc < 200) begin
        busy_n++; last = o_phase; cyc++;
        @(negedge i_clk);
      end
      chk("vec_busy_cycles", busy_n, vecs[v].exp_busy);
      chk("vec_last_phase",  last, vecs[v].exp_last);
      chk("vec_done",        o_done, 1'b1);
      @(negedge i_clk);
    end

    run_basic(1'b0);
    run_basic(1'b1);

    // Repeat mode then abort.
    launch(32'h100, 32'h100, 12'd2, 16'd2, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      chk("rep_phase", o_phase, (((c - 1) % 4) / 2 == 0) ? 32'h100 : 32'h200);
      chk("rep_done",  o_done, 1'b0);
    end
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    chk("abort_phase", o_phase, '0);
    chk("abort_busy",  o_busy, 1'b0);
    chk("abort_done",  o_done, 1'b0);
    chk("abort_strb",  o_step_strobe, 1'b0);
    @(negedge i_clk);
    chk("abort_done2", o_done, 1'b0);

    // Start with abort in IDLE.
    @(negedge i_clk);
    i_f_start = 32'h55; i_n_steps = 12'd3; i_dwell = 16'd2; i_start = 1'b1; i_abort = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0; i_abort = 1'b0;
    chk("prio_busy",  o_busy, 1'b0);
    chk("prio_phase", o_phase, '0);
    @(negedge i_clk);
    chk("prio_busy2", o_busy, 1'b0);

    // Async reset mid-run.
    launch(32'h0100_0000, 32'h0080_0000, 12'd4, 16'd3, 1'b0);
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (4) @(negedge i_clk);
    #2 i_reset = 1'b0;
    #1;
    chk("arst_phase", o_phase, '0);
    chk("arst_busy",  o_busy, 1'b0);
    chk("arst_idx",   o_step_idx, '0);
    chk("arst_strb",  o_step_strobe, 1'b0);
    chk("arst_done",  o_done, 1'b0);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("arst_nodone", o_done, 1'b0);
    run_basic(1'b0);

    // Randomized traffic; the model checker compares every cycle.
    for (int c = 0; c < 600; c++) begin
      @(negedge i_clk);
      i_start   = ($urandom_range(0, 7) == 0);
      i_abort   = ($urandom_range(0, 39) == 0);
      i_mode    = 1'($urandom_range(0, 1));
      i_f_start = $urandom;
      i_f_step  = ($urandom_range(0, 1) != 0) ? $urandom : W'($urandom_range(0, 255));
      i_n_steps = SW'($urandom_range(0, 5));
      i_dwell   = DW'($urandom_range(0, 4));
    end
    @(negedge i_clk);
    i_start = 1'b0; i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    chk("final_idle", o_busy, 1'b0);
    repeat (2) @(negedge i_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Frequency-sweep sequencer that drives the phase-increment input of the 8-bit-output NCO. It generates stepped-frequency stimulus for the FIR filter benches and datapath. Software or a bench loads start frequency, step, step count and dwell time, then pulses start. The block steps the NCO tuning word through the sweep, single-shot or repeating, with busy/done/abort handshakes.

Parameters:
WIDTH, 32, phase-increment / tuning-word width; matches NCO WIDTH
STEP_W, 12, width of step count and step index
DWELL_W, 16, width of per-step dwell count, in clock cycles

Ports:
i_clk  input  1  clock
i_reset  input  1  asynchronous, active-low reset
i_start  input  1  start request, sampled each cycle; honoured only in IDLE
i_abort  input  1  abort request; highest priority
i_mode  input  1  0 = single sweep, 1 = repeat sweep
i_f_start  input  WIDTH  first tuning word
i_f_step  input  WIDTH  increment added per step, unsigned, modulo 2^WIDTH
i_n_steps  input  STEP_W  number of steps; 0 treated as 1
i_dwell  input  DWELL_W  cycles per step; 0 treated as 1
o_phase  output  WIDTH  tuning word to NCO i_phase
o_step_strobe  output  1  one-cycle pulse in the first cycle of each step
o_step_idx  output  STEP_W  index of current step
o_busy  output  1  sweep in progress
o_done  output  1  one-cycle pulse on completion of a single sweep

Behaviour:
- Reset (i_reset low, async): state IDLE; all outputs 0; internal counters and config registers 0.
- All outputs are registered; no combinational input-to-output paths.
- States: IDLE, RUN, DONE.
- IDLE:
  - o_phase = 0, o_busy = 0.
  - i_start=1 and i_abort=0: latch i_f_start, i_f_step, i_n_steps, i_dwell, i_mode. Go to RUN.
  - Next cycle: o_phase = f_start, o_step_idx = 0, o_step_strobe = 1, o_busy = 1, dwell_cnt = 0.
- RUN:
  - Each step holds o_phase for exactly dwell_eff cycles, where dwell_eff = max(dwell, 1).
  - dwell_cnt increments 0..dwell_eff-1.
  - At dwell_cnt == dwell_eff-1, when step_idx < n_eff-1 (n_eff = max(n_steps, 1)): o_phase <= o_phase + f_step (wraps mod 2^WIDTH), step_idx++, strobe, dwell_cnt <= 0.
  - At the last step, repeat mode: o_phase <= f_start, step_idx <= 0, strobe, dwell_cnt <= 0. o_done is not asserted.
  - At the last step, single mode: go to DONE.
- DONE:
  - Lasts one cycle: o_done = 1, o_busy = 0, o_phase = 0, o_step_idx = 0.
  - Then IDLE.
  - i_start during DONE is ignored.
- Single-sweep o_busy high time is exactly n_eff*dwell_eff cycles.
- Config inputs are ignored while busy. A change takes effect only at the next start.
- i_start while busy: ignored, no restart.
- i_abort (any state): next cycle is IDLE with o_phase = 0, o_busy = 0, no o_done, no strobe. Abort and start in the same cycle: abort wins.
- Reset mid-sweep: immediate return to reset values; no done pulse.
- Width rules: the addition is WIDTH bits with the carry discarded. Counters compare against the latched, clamped values.

Decomposition:
- Shared package nco_pkg:
  - state enum (IDLE, RUN, DONE)
  - mode constants MODE_SINGLE = 0, MODE_REPEAT = 1
  - default WIDTH = 32
- No sub-module. The dwell counter and step counter are simple enough to stay inline.
- The NCO is instantiated beside this block at the stimulus top level, not inside it.

Test Plan:
- Basic single sweep. Stimulus: f_start=0x01000000, f_step=0x00800000, n=4, dwell=3, mode=0, pulse start. Response: o_phase sequence is 0x01000000 ×3, 0x01800000 ×3, 0x02000000 ×3, 0x02800000 ×3; strobes on cycles 1,4,7,10 after start; busy high 12 cycles; o_done pulse on cycle 13; o_phase=0 after.
- Wrap-around. Stimulus: f_start=0xFFFFFFF0, f_step=0x20, n=2, dwell=1. Response: o_phase = 0xFFFFFFF0 then 0x00000010; done after 2 busy cycles.
- Repeat mode. Stimulus: n=2, dwell=2, f_start=0x100, f_step=0x100, mode=1. Response: o_phase repeats 0x100,0x100,0x200,0x200 indefinitely; o_done never asserted. Then abort: o_phase=0 and busy=0 the next cycle, no done.
- Clamping and ignored start. Stimulus: n=0, dwell=0. Response: exactly one busy cycle at f_start, then done. Also: i_start pulsed mid-sweep with new config gives no change to the sequence.
- Priority. Stimulus: start and abort together in IDLE. Response: remains IDLE, busy=0.
- Reset mid-RUN. Stimulus: reset asserted during RUN. Response: all outputs 0 asynchronously, no done pulse. After release, a fresh start works normally.
